// File: rtl/eds_trig_gen.sv
// EDS trigger generator: while a frame is enabled, emits periodic fixed-width pulses on the
// selected PMT channels, counts them, and strobes frame start/end. All outputs are registered.
module eds_trig_gen #(
  parameter int unsigned PERIOD_MIN = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        eds_frame_en_i,
  input  logic [2:0]  eds_frame_sel_i,
  input  logic [31:0] trig_period_i,
  input  logic [15:0] trig_width_i,
  output logic [2:0]  pmt_trig_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [31:0] trig_cnt_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [31:0] PeriodMin = 32'(PERIOD_MIN);

  state_e      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] period_q, period_d;
  logic [31:0] width_q, width_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic [2:0]  pmt_q, pmt_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        busy_q, busy_d;

  logic [31:0] period_eff;
  logic [31:0] width_ext;
  logic [31:0] width_lo;
  logic [31:0] width_eff;
  logic        pulse_active;
  logic        pulse_last;

  // Clamp the requested timing so every period has at least one high and one low cycle.
  always_comb begin
    period_eff = (trig_period_i < PeriodMin) ? PeriodMin : trig_period_i;
    width_ext  = {16'd0, trig_width_i};
    width_lo   = (width_ext == 32'd0) ? 32'd1 : width_ext;
    width_eff  = (width_lo > period_eff - 32'd1) ? period_eff - 32'd1 : width_lo;
  end

  assign pulse_active = (cnt_q < width_q);
  assign pulse_last   = (cnt_q == width_q - 32'd1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    period_d = period_q;
    width_d  = width_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    start_d  = 1'b0;
    end_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (eds_frame_en_i && (|eds_frame_sel_i)) begin
          state_d  = StStart;
          sel_d    = eds_frame_sel_i;
          period_d = period_eff;
          width_d  = width_eff;
          cnt_d    = 32'd0;
          tcnt_d   = 32'd0;
          start_d  = 1'b1;
        end
      end
      StStart: begin
        state_d = StRun;
        cnt_d   = 32'd0;
        tcnt_d  = tcnt_q + 32'd1;
      end
      StRun: begin
        if (eds_frame_en_i) begin
          cnt_d = (cnt_q == period_q - 32'd1) ? 32'd0 : cnt_q + 32'd1;
          if (cnt_d == 32'd0) begin
            tcnt_d = tcnt_q + 32'd1;
          end
        end else if (pulse_active && !pulse_last) begin
          state_d = StDrain;
          cnt_d   = cnt_q + 32'd1;
        end else begin
          state_d = StDone;
          end_d   = 1'b1;
        end
      end
      StDrain: begin
        // Enable is ignored here; the pulse always runs to its full width.
        if (pulse_last) begin
          state_d = StDone;
          end_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    pmt_d = '0;
    if ((state_d == StRun || state_d == StDrain) && (cnt_d < width_q)) begin
      pmt_d = sel_q;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      period_q <= '0;
      width_q  <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      pmt_q    <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      period_q <= period_d;
      width_q  <= width_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      pmt_q    <= pmt_d;
      start_q  <= start_d;
      end_q    <= end_d;
      busy_q   <= busy_d;
    end
  end

  assign pmt_trig_o    = pmt_q;
  assign frame_start_o = start_q;
  assign frame_end_o   = end_q;
  assign trig_cnt_o    = tcnt_q;
  assign busy_o        = busy_q;

endmodule
